// File: rtl/ftdi_cmd_writer_if.sv
// Byte-FIFO read side and memory write port of the FTDI command writer.
// master = the command writer, slave = the FIFO / memory environment.
interface ftdi_cmd_writer_if #(
  parameter int DATA_BYTES = 2,
  parameter int AW         = 25
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_rd;
  logic                    mem_idle;
  logic                    mem_ack;
  logic                    mem_wr_req;
  logic [AW-1:0]           mem_wr_addr;
  logic [8*DATA_BYTES-1:0] mem_wr_data;

  modport master (
    input  in_data, in_valid, mem_idle, mem_ack,
    output in_rd, mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output in_data, in_valid, mem_idle, mem_ack,
    input  in_rd, mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/ftdi_cmd_writer.sv
// Framed USB command parser issuing one memory write per payload word.
// Optional FILL command (SIG_WRITE+1) is enabled by defining FTDI_CMD_FILL_EN.
module ftdi_cmd_writer #(
  parameter int          DATA_BYTES = 2,
  parameter int          AW         = 25,
  parameter int          LW         = 16,
  parameter logic [15:0] SIG_WRITE  = 16'hAA55
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  ftdi_cmd_writer_if.master    bus,
  output logic                 busy,
  output logic                 cmd_done,
  output logic [7:0]           sync_err_cnt
);

  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [1:0] {HDR, ADDR, DATA, WRITE} state_t;

  state_t          state, state_nxt;
  logic [23:0]     win;
  logic [1:0]      win_cnt;
  logic [1:0]      byte_cnt;
  logic [LW-1:0]   len_reg;
  logic [LW-1:0]   word_cnt;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   data_reg;
  logic            req;

  logic [31:0]     cand;
  logic            win_full;
  logic            sig_hit;
  logic            take;
  logic            field_last;
  logic            ack_take;
  logic            last_word;
`ifdef FTDI_CMD_FILL_EN
  logic            fill_hit;
  logic            fill_cmd;
`endif

  always_comb begin
    cand       = {bus.in_data, win};
    win_full   = (win_cnt == 2'd3);
    sig_hit    = win_full && (cand[31:16] == SIG_WRITE);
`ifdef FTDI_CMD_FILL_EN
    fill_hit   = win_full && (cand[31:16] == SIG_WRITE + 16'd1);
`endif
    take       = 1'b0;
    case (state)
      HDR:        take = bus.in_valid & bus.mem_idle;
      ADDR, DATA: take = bus.in_valid;
      default:    take = 1'b0;
    endcase
    field_last = (state == ADDR) ? (byte_cnt == 2'd3) : (byte_cnt == 2'(DATA_BYTES - 1));
    ack_take   = req & bus.mem_ack;
    last_word  = (word_cnt == len_reg - LW'(1));

    state_nxt  = state;
    case (state)
      HDR: begin
`ifdef FTDI_CMD_FILL_EN
        if (take && (sig_hit || fill_hit)) state_nxt = ADDR;
`else
        if (take && sig_hit) state_nxt = ADDR;
`endif
      end
      ADDR: if (take && field_last) state_nxt = (len_reg == '0) ? HDR : DATA;
      DATA: if (take && field_last) state_nxt = WRITE;
      WRITE: begin
        if (ack_take) begin
`ifdef FTDI_CMD_FILL_EN
          // FILL reuses the captured word, so it never returns to DATA
          state_nxt = last_word ? HDR : (fill_cmd ? WRITE : DATA);
`else
          state_nxt = last_word ? HDR : DATA;
`endif
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) state <= HDR;
    else      state <= state_nxt;
  end

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      win          <= '0;
      win_cnt      <= '0;
      byte_cnt     <= '0;
      len_reg      <= '0;
      word_cnt     <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      req          <= 1'b0;
      cmd_done     <= 1'b0;
      sync_err_cnt <= '0;
`ifdef FTDI_CMD_FILL_EN
      fill_cmd     <= 1'b0;
`endif
    end else begin
      cmd_done <= 1'b0;
      case (state)
        HDR: begin
          if (take) begin
            win <= cand[31:8];
            if (!win_full) win_cnt <= win_cnt + 2'd1;
            if (state_nxt == ADDR) begin
              len_reg  <= cand[LW-1:0];
              byte_cnt <= '0;
              win_cnt  <= '0;
`ifdef FTDI_CMD_FILL_EN
              fill_cmd <= fill_hit;
`endif
            end else if (win_full && sync_err_cnt != 8'hFF) begin
              sync_err_cnt <= sync_err_cnt + 8'd1;
            end
          end
        end
        ADDR: begin
          // address bytes reuse the window shifter; the last byte completes it
          if (take) begin
            win      <= cand[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (field_last) begin
              addr_reg <= cand[AW-1:0];
              byte_cnt <= '0;
              word_cnt <= '0;
              if (len_reg == '0) begin
                cmd_done <= 1'b1;
                win_cnt  <= '0;
              end
            end
          end
        end
        DATA: begin
          if (take) begin
            data_reg[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt <= field_last ? 2'd0 : byte_cnt + 2'd1;
            if (field_last) req <= 1'b1;
          end
        end
        WRITE: begin
          if (ack_take) begin
            req      <= 1'b0;
            addr_reg <= addr_reg + AW'(1);
            word_cnt <= word_cnt + LW'(1);
            if (last_word) begin
              cmd_done <= 1'b1;
              win_cnt  <= '0;
            end
          end else if (!req) begin
            req <= 1'b1;
          end
        end
        default: req <= 1'b0;
      endcase
    end
  end

  assign bus.in_rd       = take;
  assign bus.mem_wr_req  = req;
  assign bus.mem_wr_addr = addr_reg;
  assign bus.mem_wr_data = data_reg;
  assign busy            = (state != HDR);

endmodule

// File: tb/tb_ftdi_cmd_writer.sv
// Directed bench for ftdi_cmd_writer: FIFO byte source, memory ack model, write log.
module tb_ftdi_cmd_writer;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       cmd_done;
  logic [7:0] sync_err_cnt;

  ftdi_cmd_writer_if #(.DATA_BYTES(2), .AW(25)) bus ();

  ftdi_cmd_writer #(.DATA_BYTES(2), .AW(25), .LW(16), .SIG_WRITE(16'hAA55)) dut (
    .mem_clk      (clk),
    .rst          (rst_n),
    .bus          (bus),
    .busy         (busy),
    .cmd_done     (cmd_done),
    .sync_err_cnt (sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  stim[$];
  int          rd_ptr = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  int          stall_err = 0;
  int          rd_in_write = 0;
  int          ack_delay = 1;
  int          wait_cnt = 0;
  logic        held = 1'b0;
  logic [24:0] h_addr;
  logic [15:0] h_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO pop, write logging and stall monitor, all on old (pre-edge) values
  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_rd) rd_ptr++;
    if (rst_n && cmd_done) done_cnt++;
    if (rst_n && bus.mem_wr_req) begin
      if (held && (bus.mem_wr_addr != h_addr || bus.mem_wr_data != h_data)) stall_err++;
      if (bus.in_valid && bus.in_rd) rd_in_write++;
      held   = !bus.mem_ack;
      h_addr = bus.mem_wr_addr;
      h_data = bus.mem_wr_data;
      if (bus.mem_ack) begin
        wa_q.push_back({7'd0, bus.mem_wr_addr});
        wd_q.push_back({16'd0, bus.mem_wr_data});
      end
    end else begin
      held = 1'b0;
    end
  end

  always @(negedge clk) begin
    bus.in_valid = (rd_ptr < stim.size());
    bus.in_data  = bus.in_valid ? stim[rd_ptr] : 8'h00;
    if (bus.mem_wr_req) begin
      bus.mem_ack = (wait_cnt >= ack_delay);
      wait_cnt++;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  task automatic push(input logic [7:0] b);
    stim.push_back(b);
  endtask

  task automatic push_hdr(input logic [15:0] len, input logic [15:0] sig, input logic [31:0] addr);
    push(len[7:0]);  push(len[15:8]);
    push(sig[7:0]);  push(sig[15:8]);
    push(addr[7:0]); push(addr[15:8]); push(addr[23:16]); push(addr[31:24]);
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (rd_ptr < stim.size() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_drained"}, 32'(rd_ptr >= stim.size()), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] ga, gd;
    ga = (idx < wa_q.size()) ? wa_q[idx] : 32'hDEAD_BEEF;
    gd = (idx < wd_q.size()) ? wd_q[idx] : 32'hDEAD_BEEF;
    check_val({tag, "_addr"}, ga, ea);
    check_val({tag, "_data"}, gd, ed);
  endtask

  initial begin
    int wb, db, rb;
    bus.mem_idle = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_req",  32'(bus.mem_wr_req), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(cmd_done), 32'd0);
    check_val("rst_sync", 32'(sync_err_cnt), 32'd0);
    check_val("rst_rd",   32'(bus.in_rd), 32'd0);
    check_val("rst_addr", 32'(bus.mem_wr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic 4-word WRITE
    wb = wa_q.size(); db = done_cnt;
    push_hdr(16'd4, 16'hAA55, 32'h0000_C810);
    for (int i = 0; i < 8; i++) push(8'(i));
    wait_done("w4", db + 1);
    check_val("w4_count", 32'(wa_q.size() - wb), 32'd4);
    check_write("w4_0", wb + 0, 32'hC810, 32'h0100);
    check_write("w4_1", wb + 1, 32'hC811, 32'h0302);
    check_write("w4_2", wb + 2, 32'hC812, 32'h0504);
    check_write("w4_3", wb + 3, 32'hC813, 32'h0706);
    check_val("w4_done_cnt", 32'(done_cnt - db), 32'd1);
    check_val("w4_busy", 32'(busy), 32'd0);

    // header bytes wait for mem_idle; then resync past three garbage bytes
    wb = wa_q.size(); db = done_cnt; rb = rd_ptr;
    bus.mem_idle = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    push_hdr(16'd1, 16'hAA55, 32'h0000_0040);
    push(8'h34); push(8'h12);
    repeat (4) @(negedge clk);
    check_val("idle_hold", 32'(rd_ptr - rb), 32'd0);
    bus.mem_idle = 1'b1;
    wait_done("rs", db + 1);
    check_val("rs_sync", 32'(sync_err_cnt), 32'd3);
    check_val("rs_count", 32'(wa_q.size() - wb), 32'd1);
    check_write("rs_0", wb, 32'h40, 32'h1234);

    // len=0 frame followed by a normal frame
    wb = wa_q.size(); db = done_cnt;
    push_hdr(16'd0, 16'hAA55, 32'h0000_0020);
    push_hdr(16'd1, 16'hAA55, 32'h0000_0030);
    push(8'hAB); push(8'hCD);
    wait_done("l0", db + 2);
    check_val("l0_done_cnt", 32'(done_cnt - db), 32'd2);
    check_val("l0_count", 32'(wa_q.size() - wb), 32'd1);
    check_write("l0_0", wb, 32'h30, 32'hCDAB);

    // stalled ack plus address wrap at the top of the AW space
    wb = wa_q.size(); db = done_cnt;
    stall_err = 0; rd_in_write = 0;
    ack_delay = 5;
    push_hdr(16'd2, 16'hAA55, 32'h01FF_FFFF);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_done("st", db + 1);
    check_val("st_count", 32'(wa_q.size() - wb), 32'd2);
    check_write("st_0", wb + 0, 32'h01FF_FFFF, 32'h2211);
    check_write("st_1", wb + 1, 32'h0000_0000, 32'h4433);
    check_val("st_hold", 32'(stall_err), 32'd0);
    check_val("st_no_rd", 32'(rd_in_write), 32'd0);
    ack_delay = 1;

    // reset in WRITE with req pending, then a clean frame
    ack_delay = 1000;
    push_hdr(16'd1, 16'hAA55, 32'h0000_0050);
    push(8'h02); push(8'h01);
    begin
      int n = 0;
      while (!bus.mem_wr_req && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check_val("rr_req_seen", 32'(bus.mem_wr_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rr_req_drop", 32'(bus.mem_wr_req), 32'd0);
    check_val("rr_busy", 32'(busy), 32'd0);
    check_val("rr_sync", 32'(sync_err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    ack_delay = 1;
    rst_n = 1'b1;
    @(negedge clk);
    wb = wa_q.size(); db = done_cnt;
    push_hdr(16'd1, 16'hAA55, 32'h0000_0060);
    push(8'h0B); push(8'h0A);
    wait_done("rr", db + 1);
    check_val("rr_count", 32'(wa_q.size() - wb), 32'd1);
    check_write("rr_0", wb, 32'h60, 32'h0A0B);

    // FILL signature
    wb = wa_q.size(); db = done_cnt; rb = rd_ptr;
    push_hdr(16'd3, 16'hAA56, 32'h0000_0100);
    push(8'hBE); push(8'hEF);
`ifdef FTDI_CMD_FILL_EN
    wait_done("fl", db + 1);
    check_val("fl_count", 32'(wa_q.size() - wb), 32'd3);
    check_write("fl_0", wb + 0, 32'h100, 32'hEFBE);
    check_write("fl_1", wb + 1, 32'h101, 32'hEFBE);
    check_write("fl_2", wb + 2, 32'h102, 32'hEFBE);
    check_val("fl_bytes", 32'(rd_ptr - rb), 32'd10);
    check_val("fl_done_cnt", 32'(done_cnt - db), 32'd1);
    check_val("fl_sync", 32'(sync_err_cnt), 32'd0);
`else
    wait_drained("nf");
    check_val("nf_count", 32'(wa_q.size() - wb), 32'd0);
    check_val("nf_bytes", 32'(rd_ptr - rb), 32'd10);
    check_val("nf_done_cnt", 32'(done_cnt - db), 32'd0);
    check_val("nf_sync", 32'(sync_err_cnt), 32'd7);
`endif
    check_val("fl_busy", 32'(busy), 32'd0);

    // error counter saturation
    for (int i = 0; i < 300; i++) push(8'h00);
    wait_drained("sat");
    check_val("sat_sync", 32'(sync_err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ftdi_cmd_writer.md
Name: ftdi_cmd_writer

Overview:
- Single-clock command parser and memory writer. Sits between the ft_clk→mem_clk byte FIFO (show-ahead, outside this block) and the memory write port.
- Parses framed commands from the USB byte stream and issues one memory write per payload word. Uses the existing req/ack handshake.
- Successor of the fixed 16-bit pixel loader: parametrised word/address/length widths, hardened resync, len=0 handling, data valid at request, optional FILL command.

Parameters:
- DATA_BYTES, 2, payload bytes per memory word (1..4); mem_wr_data width = 8*DATA_BYTES
- AW, 25, memory word-address width (1..32)
- LW, 16, length field width used (1..16)
- SIG_WRITE, 16'hAA55, signature for the WRITE command

Ports:
- mem_clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- in_data  in  8  FIFO head byte, valid while in_valid=1 (show-ahead)
- in_valid  in  1  FIFO not empty
- in_rd  out  1  pop; byte consumed on any cycle with in_valid & in_rd
- mem_idle  in  1  memory controller idle; header bytes consumed only while 1
- mem_ack  in  1  write accepted
- mem_wr_req  out  1  write request, held until mem_ack
- mem_wr_addr  out  AW  word address
- mem_wr_data  out  8*DATA_BYTES  write data
- busy  out  1  state != HDR
- cmd_done  out  1  one-cycle pulse at command completion
- sync_err_cnt  out  8  saturating count of discarded header bytes

Behaviour:
- Reset (rst=0, async): state=HDR; mem_wr_req=0; busy=0; cmd_done=0; sync_err_cnt=0; addr/data/word counter/window/byte counters=0; in_rd=0.
- in_rd = in_valid & consuming state & (state!=HDR | mem_idle). in_rd is never asserted in WRITE.
- Frame format, little-endian: bytes 0-1 = len, bytes 2-3 = signature, bytes 4-7 = address (low AW bits used, rest ignored), then len words of DATA_BYTES bytes each, LSB first. len uses bits [LW-1:0].
- HDR: 32-bit sliding window. Each consumed byte shifts in at the top. Match is evaluated combinationally on {in_data, win[31:8]}, and only once ≥4 bytes have entered since entry to HDR.
  - Match → ADDR.
  - Full window without match → sync_err_cnt+1 (saturates at 255); stay in HDR and keep sliding (one-byte resync).
- ADDR: consume 4 bytes.
  - If len==0: cmd_done pulse, → HDR, no memory writes.
  - Else → DATA, word counter cleared.
- DATA: consume DATA_BYTES bytes into the data register. The cycle after the last byte is consumed: mem_wr_req=1, state=WRITE.
- WRITE: mem_wr_addr and mem_wr_data are stable from req rise until the ack cycle. On mem_ack:
  - mem_wr_req=0 next cycle; addr+1 modulo 2^AW; word counter +1.
  - If counter==len-1: cmd_done pulse, → HDR (window count cleared). Else → DATA.
- mem_ack while mem_wr_req=0 is ignored.
- Ack in the same cycle as req rise counts as accepted.
- Back-to-back throughput: one write per (DATA_BYTES+1) cycles minimum when FIFO not empty and ack immediate.
- FIFO empty mid-field: partial byte count is held; no timeout.
- Reset asserted mid-command: abort immediately, return to reset state; the partial command is lost.

Optional Feature:
- Macro FTDI_CMD_FILL_EN.
- Defined: signature SIG_WRITE+1 (16'hAA56) is a FILL command. After ADDR, consume one word in DATA, then issue len writes of that word to addr, addr+1, … with no further FIFO reads.
  - Between writes: req drops for one cycle after each ack, then reasserts.
  - cmd_done pulses after the last ack.
  - len==0 behaves as for WRITE.
- Not defined: 16'hAA56 is an ordinary non-matching header; window keeps sliding.

Test Plan:
- WRITE, DATA_BYTES=2: bytes 04 00 55 AA 10 C8 00 00, payload 00..07, ack one cycle after each req → 4 writes: addr 0xC810..0xC813, data 0x0100, 0x0302, 0x0504, 0x0706; cmd_done once; busy low after.
- Resync: 3 garbage bytes 11 22 33, then a len=1 WRITE frame → sync_err_cnt=3 (first counted at byte 4), single write performed correctly.
- len=0 frame to addr 0x20 → no mem_wr_req, cmd_done pulses, next frame parsed normally.
- Ack stalled 5 cycles → req, addr and data held constant; no FIFO reads during the stall. Address wrap: AW=8, addr=0xFF, len=2 → writes at 0xFF then 0x00.
- Reset (rst low) while in WRITE with req=1 → req=0 immediately; after release, the next full frame is parsed from HDR.
- FTDI_CMD_FILL_EN defined: frame 03 00 56 AA 00 01 00 00, word BE EF → 3 writes of 0xEFBE to 0x100..0x102, exactly 10 bytes consumed. Without the macro: no writes, 10-byte stream only slides the window.
